// File: rtl/mux_stream_rr.sv
// Registered N-channel stream multiplexer: manual-select or round-robin choice
// feeds a single output register with one-cycle latency and full throughput.
module mux_stream_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [NCH-1:0]       VALID_IN,
    output logic [NCH-1:0]       READY_IN,
    input  logic                 MODE,
    input  logic [SELW-1:0]      SEL,
    output logic [WIDTH-1:0]     Y,
    output logic                 VALID_OUT,
    input  logic                 READY_OUT,
    output logic [SELW-1:0]      GRANT
);

    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  grant_q, grant_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             can_load;
    logic             chosen_ok;
    logic [SELW-1:0]  chosen;
    logic [SELW-1:0]  rr_idx;
    logic [WIDTH-1:0] chosen_data;

    // The register may take a new word when empty or drained this cycle.
    assign can_load = !valid_q || READY_OUT;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        chosen    = '0;
        chosen_ok = 1'b0;
        rr_idx    = '0;
        if (!MODE) begin
            chosen = SEL;
            for (int i = 0; i < NCH; i++) begin
                if (SEL == SELW'(i)) chosen_ok = VALID_IN[i];
            end
        end else begin
            // Scan farthest-to-nearest so the first valid channel after PTR wins.
            for (int k = NCH; k >= 1; k--) begin
                rr_idx = SELW'((int'(ptr_q) + k) % NCH);
                if (VALID_IN[rr_idx]) begin
                    chosen    = rr_idx;
                    chosen_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chosen_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chosen == SELW'(i)) chosen_data = D[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        READY_IN = '0;
        for (int i = 0; i < NCH; i++) begin
            READY_IN[i] = can_load && chosen_ok && (chosen == SELW'(i));
        end
    end

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (can_load) begin
            valid_d = chosen_ok;
            if (chosen_ok) begin
                y_d     = chosen_data;
                grant_d = chosen;
                ptr_d   = chosen;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RST_N) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q   <= SELW'(NCH - 1);
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Y         = y_q;
    assign VALID_OUT = valid_q;
    assign GRANT     = grant_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr: a reference model predicts each accepted
// word from the arbitration rules; a monitor checks words as they leave.
module tb_mux_stream_rr;

    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [NCH*WIDTH-1:0] D;
    logic [NCH-1:0]       VALID_IN;
    logic [NCH-1:0]       READY_IN;
    logic                 MODE;
    logic [SELW-1:0]      SEL;
    logic [WIDTH-1:0]     Y;
    logic                 VALID_OUT;
    logic                 READY_OUT;
    logic [SELW-1:0]      GRANT;

    mux_stream_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK(CLK), .RST_N(RST_N), .D(D), .VALID_IN(VALID_IN), .READY_IN(READY_IN),
        .MODE(MODE), .SEL(SEL), .Y(Y), .VALID_OUT(VALID_OUT), .READY_OUT(READY_OUT),
        .GRANT(GRANT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  ch;
    } exp_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    bit             model_en = 1'b0;
    int             m_ptr    = NCH - 1;
    logic [NCH-1:0] acc      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: manual takes SEL if valid; round-robin takes the first
    // valid channel strictly after the last winner, wrapping around.
    function automatic void pick(input logic mode, input logic [SELW-1:0] sel,
                                 input logic [NCH-1:0] vin, input int ptr,
                                 output bit ok, output int ch);
        ok = 1'b0;
        ch = 0;
        if (!mode) begin
            ch = int'(sel);
            ok = (ch < NCH) && vin[sel];
        end else begin
            for (int step = 1; step <= NCH && !ok; step++) begin
                if (vin[(ptr + step) % NCH]) begin
                    ok = 1'b1;
                    ch = (ptr + step) % NCH;
                end
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (model_en && RST_N) begin
            check("valid_out", VALID_OUT, sb.size() != 0);
            if (VALID_OUT && sb.size() != 0) begin
                check("y", Y, sb[0].data);
                check("grant", GRANT, sb[0].ch);
                if (READY_OUT) void'(sb.pop_front());
            end
        end
    end

    always @(negedge CLK) begin : model
        bit             ok;
        int             ch;
        logic [NCH-1:0] exp_rdy;
        #1;
        acc = '0;
        if (model_en && RST_N) begin
            pick(MODE, SEL, VALID_IN, m_ptr, ok, ch);
            exp_rdy = '0;
            if ((READY_OUT || sb.size() == 0) && ok) begin
                exp_rdy[ch] = 1'b1;
                sb.push_back('{data: D[ch*WIDTH +: WIDTH], ch: SELW'(ch)});
                m_ptr   = ch;
                acc[ch] = 1'b1;
            end
            check("ready_in", READY_IN, exp_rdy);
        end
    end

    task automatic do_reset_async();
        @(posedge CLK);
        #3;
        model_en = 1'b0;
        RST_N    = 1'b0;
        #1;
        check("rst_y", Y, 0);
        check("rst_valid_out", VALID_OUT, 0);
        check("rst_grant", GRANT, 0);
        sb.delete();
        m_ptr = NCH - 1;
        @(posedge CLK);
        #1;
        RST_N    = 1'b1;
        model_en = 1'b1;
    endtask

    task automatic idle(input int n);
        VALID_IN  = '0;
        READY_OUT = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        D = '0; VALID_IN = '0; MODE = 1'b0; SEL = '0; READY_OUT = 1'b0;
        RST_N = 1'b0;
        #2;
        check("init_y", Y, 0);
        check("init_valid_out", VALID_OUT, 0);
        check("init_grant", GRANT, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_en = 1'b1;

        // Manual select of channel 2.
        MODE = 1'b0; SEL = 2'd2; VALID_IN = 4'b0100; D[2*WIDTH +: WIDTH] = 4'hA; READY_OUT = 1'b1;
        #1;
        check("t1_ready_in", READY_IN, 4'b0100);
        @(posedge CLK);
        @(negedge CLK);
        check("t1_y", Y, 4'hA);
        check("t1_valid_out", VALID_OUT, 1);
        check("t1_grant", GRANT, 2);
        @(posedge CLK);
        #1;
        idle(3);

        // Round-robin over four always-valid channels starts at channel 0.
        do_reset_async();
        MODE = 1'b1; D = {4'h4, 4'h3, 4'h2, 4'h1}; VALID_IN = 4'b1111; READY_OUT = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("t2_grant", GRANT, k % 4);
            check("t2_y", Y, (k % 4) + 1);
        end

        // PTR=1 via a manual grant, then round-robin between ch1 and ch3.
        @(posedge CLK);
        #1;
        MODE = 1'b0; SEL = 2'd1; VALID_IN = 4'b0010;
        @(posedge CLK);
        #1;
        MODE = 1'b1; VALID_IN = 4'b1010;
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("t3_grant", GRANT, (k % 2 == 0) ? 3 : 1);
            check("t3_y", Y, (k % 2 == 0) ? 4 : 2);
        end
        @(posedge CLK);
        #1;
        idle(3);

        // Backpressure holds Y; release drains and reloads on the same edge.
        MODE = 1'b0; SEL = 2'd0; VALID_IN = 4'b0001; D[0 +: WIDTH] = 4'h5; READY_OUT = 1'b1;
        @(posedge CLK);
        #1;
        READY_OUT = 1'b0;
        D[0 +: WIDTH] = 4'h6;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t4_hold_y", Y, 4'h5);
            check("t4_ready_in", READY_IN, 4'b0000);
        end
        @(posedge CLK);
        #1;
        READY_OUT = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("t4_reload_y", Y, 4'h6);
        @(posedge CLK);
        #1;
        idle(3);

        // Manual select of an idle channel stalls; round-robin then picks ch1.
        MODE = 1'b0; SEL = 2'd2; VALID_IN = 4'b1011; READY_OUT = 1'b1;
        #1;
        check("t5_ready_in", READY_IN, 4'b0000);
        @(posedge CLK);
        @(negedge CLK);
        check("t5_valid_out", VALID_OUT, 0);
        @(posedge CLK);
        #1;
        MODE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("t5_rr_grant", GRANT, 1);
        check("t5_rr_valid", VALID_OUT, 1);

        // Mid-stream asynchronous reset, then round-robin restarts at ch0.
        VALID_IN = 4'b1111;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("t6_pre_valid", VALID_OUT, 1);
        do_reset_async();
        @(posedge CLK);
        @(negedge CLK);
        check("t6_first_grant", GRANT, 0);
        @(posedge CLK);
        #1;
        idle(3);

        // Random traffic: producers hold each word until the model sees it accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset_async();
            @(posedge CLK);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (!VALID_IN[i] || acc[i] || !RST_N) begin
                    VALID_IN[i] = ($urandom_range(0, 3) != 0);
                    D[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            READY_OUT = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) MODE = ~MODE;
            if ($urandom_range(0, 3) == 0) SEL = SELW'($urandom);
        end

        idle(6);
        check("drain_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
